// File: rtl/bitty_core_gen.sv
// Bitty gen-2 core: multi-cycle FSM sharing one req/ack memory port.
// Optional perf counters are enabled by defining BITTY_PERF_CNT_EN.
module bitty_core_gen #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              done,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] last_result
`ifdef BITTY_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  localparam logic [1:0] F_RTYPE = 2'b00;
  localparam logic [1:0] F_ITYPE = 2'b01;
  localparam logic [1:0] F_BRCH  = 2'b10;
  localparam logic [1:0] F_LDST  = 2'b11;

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] s_q;
  logic [DATA_W-1:0] c_q;
  logic [15:0]       ir;
  logic [1:0]        cmp_flag;
  logic [ADDR_W-1:0] pc_q;

  logic [1:0]        fmt;
  logic [2:0]        rx;
  logic [2:0]        ry;
  logic [2:0]        op;
  logic [1:0]        cond;
  logic              is_load;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] ls_addr;
  logic              taken;
  logic              wb_en;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic [1:0]        flag_nx;

  assign fmt     = ir[1:0];
  assign rx      = ir[15:13];
  assign ry      = ir[12:10];
  assign op      = ir[4:2];
  assign cond    = ir[3:2];
  assign is_load = ir[2];
  assign imm     = DATA_W'(ir[12:5]);
  assign tgt     = ADDR_W'(ir[15:4]);
  assign ls_addr = rf[ry][ADDR_W-1:0];
  assign taken   = (cond == 2'b11)
                || (cond == cmp_flag);
  assign wb_en   = (fmt == F_RTYPE)
                || (fmt == F_ITYPE)
                || (fmt == F_LDST && is_load);

  // Operand a comes from S, latched in DECODE
  always_comb begin
    alu_a   = s_q;
    alu_b   = (fmt == F_RTYPE) ? rf[ry] : imm;
    alu_res = '0;
    flag_nx = cmp_flag;
    unique case (op)
      3'b000: alu_res = alu_a + alu_b;
      3'b001: alu_res = alu_a - alu_b;
      3'b010: alu_res = alu_a & alu_b;
      3'b011: alu_res = alu_a | alu_b;
      3'b100: alu_res = alu_a ^ alu_b;
      3'b101: alu_res = alu_a << alu_b[SH_W-1:0];
      3'b110: alu_res = alu_a >> alu_b[SH_W-1:0];
      3'b111: begin
        if (alu_a == alu_b) begin
          alu_res = '0;
          flag_nx = 2'b00;
        end else if (alu_a > alu_b) begin
          alu_res = DATA_W'(1);
          flag_nx = 2'b01;
        end else begin
          alu_res = DATA_W'(2);
          flag_nx = 2'b10;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (run) state_nx = FETCH;
      FETCH:  if (mem_ack) state_nx = DECODE;
      DECODE: state_nx = EXEC;
      EXEC:   state_nx = (fmt == F_LDST) ? MEM : WB;
      MEM:    if (mem_ack) state_nx = WB;
      WB:     state_nx = run ? FETCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Requests are gated by reset so they drop in the reset cycle itself
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      FETCH: begin
        mem_req  = !reset;
        mem_addr = pc_q;
      end
      MEM: begin
        mem_req  = !reset;
        mem_we   = !reset && !is_load;
        mem_addr = ls_addr;
        if (!is_load) mem_wdata = rf[rx];
      end
      WB:      done = !reset;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      s_q      <= '0;
      c_q      <= '0;
      ir       <= '0;
      cmp_flag <= 2'b11;
      pc_q     <= RESET_PC;
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_ack) ir <= mem_rdata[15:0];
        end
        DECODE: begin
          s_q  <= rf[rx];
          pc_q <= pc_q + ADDR_W'(1);
        end
        EXEC: begin
          if (fmt == F_RTYPE || fmt == F_ITYPE) begin
            c_q      <= alu_res;
            cmp_flag <= flag_nx;
          end
          if (fmt == F_BRCH && taken) pc_q <= tgt;
        end
        MEM: begin
          if (mem_ack && is_load) c_q <= mem_rdata;
        end
        WB: begin
          if (wb_en) rf[rx] <= c_q;
        end
        default: ;
      endcase
    end
  end

  assign pc          = pc_q;
  assign last_result = c_q;

`ifdef BITTY_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (done) retired_cnt <= retired_cnt + 32'd1;
      if (mem_req && !mem_ack) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
